// File: rtl/conway_board_scanner.sv
// conway_board_scanner
// --------------------
// Sequencer at the output end of the conway_cell array. On start it snapshots
// the board state, raster-scans the snapshot out as a 1-bit pixel stream
// (FRAMES_PER_STEP full frames) over a valid/ready handshake, then issues a
// single-cycle ena strobe so every cell advances one generation. A settle
// cycle follows so cells_q reflects the new generation before the next
// snapshot can be taken.
//
// Ports
//   clk        in   system clock, all logic on posedge
//   rst        in   synchronous active-high reset
//   cells_q    in   board state, cell (r,c) at bit r*COLS+c
//   run        in   level, free-running generation stepping
//   step_req   in   pulse, request exactly one generation (held if busy)
//   ena        out  one-cycle generation-advance strobe
//   pix_valid  out  pixel stream valid
//   pix_ready  in   downstream accepts pixel
//   pix_data   out  cell state of current pixel
//   pix_row    out  row index of current pixel
//   pix_col    out  column index of current pixel
//   pix_last   out  current pixel is the last of a frame
//   busy       out  high whenever the sequencer is not idle
//   gen_count  out  generations stepped since reset (wraps silently)
module conway_board_scanner #(
    parameter int ROWS            = 8,
    parameter int COLS            = 8,
    parameter int FRAMES_PER_STEP = 1,
    parameter int GEN_W           = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ROWS*COLS-1:0]    cells_q,
    input  logic                    run,
    input  logic                    step_req,
    output logic                    ena,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic                    pix_data,
    output logic [$clog2(ROWS)-1:0] pix_row,
    output logic [$clog2(COLS)-1:0] pix_col,
    output logic                    pix_last,
    output logic                    busy,
    output logic [GEN_W-1:0]        gen_count
);

    localparam int N  = ROWS * COLS;
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_STEP,
        S_SETTLE
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_snap;
    logic [RW-1:0]   r_row;
    logic [CW-1:0]   r_col;
    logic [FW-1:0]   r_frame;
    logic            r_pend;
    logic            r_valid;
    logic            r_data;
    logic            r_last;
    logic            r_ena;
    logic            r_busy;
    logic [GEN_W-1:0] r_gen;

    logic            w_col_end;
    logic            w_frame_end;
    logic [RW-1:0]   w_nxt_row;
    logic [CW-1:0]   w_nxt_col;
    logic [IW-1:0]   w_nxt_idx;
    logic            w_nxt_last;
    logic            w_hs;
    logic            w_go;

    // Next raster position. Only meaningful when the current pixel is not the
    // frame's last one; the frame wrap is handled explicitly in the FSM.
    always_comb begin
        w_col_end   = (r_col == CW'(COLS - 1));
        w_frame_end = w_col_end && (r_row == RW'(ROWS - 1));
        w_nxt_col   = w_col_end ? '0 : r_col + 1'b1;
        w_nxt_row   = w_col_end ? r_row + 1'b1 : r_row;
        w_nxt_idx   = IW'(w_nxt_row) * IW'(COLS) + IW'(w_nxt_col);
        w_nxt_last  = (w_nxt_row == RW'(ROWS - 1)) && (w_nxt_col == CW'(COLS - 1));
        w_hs        = r_valid && pix_ready;
        w_go        = run || r_pend || step_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_snap  <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_frame <= '0;
            r_pend  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= 1'b0;
            r_last  <= 1'b0;
            r_ena   <= 1'b0;
            r_busy  <= 1'b0;
            r_gen   <= '0;
        end else begin
            // A request seen in any state is remembered; the IDLE->SCAN
            // transition below overrides this to consume it.
            if (step_req) begin
                r_pend <= 1'b1;
            end
            r_ena <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_state <= S_SCAN;
                        r_snap  <= cells_q;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_frame <= '0;
                        r_pend  <= 1'b0;
                        r_valid <= 1'b1;
                        r_data  <= cells_q[0];
                        r_last  <= (N == 1);
                        r_busy  <= 1'b1;
                    end
                end

                S_SCAN: begin
                    // Without a handshake every pix_* register simply holds.
                    if (w_hs) begin
                        if (w_frame_end) begin
                            r_row <= '0;
                            r_col <= '0;
                            if (r_frame == FW'(FRAMES_PER_STEP - 1)) begin
                                r_state <= S_STEP;
                                r_valid <= 1'b0;
                                r_data  <= 1'b0;
                                r_last  <= 1'b0;
                                r_ena   <= 1'b1;
                            end else begin
                                r_frame <= r_frame + 1'b1;
                                r_data  <= r_snap[0];
                                r_last  <= (N == 1);
                            end
                        end else begin
                            r_row  <= w_nxt_row;
                            r_col  <= w_nxt_col;
                            r_data <= r_snap[w_nxt_idx];
                            r_last <= w_nxt_last;
                        end
                    end
                end

                S_STEP: begin
                    r_gen   <= r_gen + 1'b1;
                    r_state <= S_SETTLE;
                end

                S_SETTLE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ena       = r_ena;
    assign pix_valid = r_valid;
    assign pix_data  = r_data;
    assign pix_row   = r_row;
    assign pix_col   = r_col;
    assign pix_last  = r_last;
    assign busy      = r_busy;
    assign gen_count = r_gen;

endmodule

// File: tb/tb_conway_board_scanner.sv
// Bench for conway_board_scanner on a 4x4 board with two frames per
// generation. Expected pixels come from the snapshot value and the raster
// order (pixel k of a generation shows cell k mod 16).
module tb_conway_board_scanner;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int FPS  = 2;
    localparam int GW   = 16;
    localparam int N    = ROWS * COLS;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  cells_q;
    logic          run;
    logic          step_req;
    logic          ena;
    logic          pix_valid;
    logic          pix_ready;
    logic          pix_data;
    logic [1:0]    pix_row;
    logic [1:0]    pix_col;
    logic          pix_last;
    logic          busy;
    logic [GW-1:0] gen_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ena_cyc[$];

    always #5 clk = ~clk;

    conway_board_scanner #(
        .ROWS(ROWS), .COLS(COLS), .FRAMES_PER_STEP(FPS), .GEN_W(GW)
    ) dut (
        .clk(clk), .rst(rst), .cells_q(cells_q), .run(run), .step_req(step_req),
        .ena(ena), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_row(pix_row), .pix_col(pix_col), .pix_last(pix_last), .busy(busy),
        .gen_count(gen_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one generation's worth of pixel traffic and checks every
    // handshaken pixel against the snapshot. mode: 0 ready high, 1 ready
    // toggling, 2 random ready. Optional events fire when the handshake count
    // reaches the given value (-1 = never). stop_at returns early without
    // waiting for ena.
    task automatic scan_gen(input logic [N-1:0] snap, input int mode,
                            input int chg_at, input logic [N-1:0] chg_val,
                            input int run_off_at, input int step_at,
                            input int stop_at, input string tag);
        int hs = 0;
        int guard = 0;
        int pos;
        logic [3:0] p4;
        bit seen_ena = 0;
        bit prev_stall = 0;
        bit did_chg = 0, did_off = 0, did_step = 0;
        logic pv, pd, pl;
        logic [1:0] pr, pc;
        pv = 0; pd = 0; pl = 0; pr = 0; pc = 0;
        while (!seen_ena && guard < 400) begin
            if (stop_at >= 0 && hs == stop_at) break;
            step_req = 1'b0;
            case (mode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = (guard % 2 == 0);
                default: pix_ready = 1'($urandom_range(0, 1));
            endcase
            if (hs == chg_at && !did_chg) begin cells_q = chg_val; did_chg = 1; end
            if (hs == run_off_at && !did_off) begin run = 1'b0; did_off = 1; end
            if (hs == step_at && !did_step) begin step_req = 1'b1; did_step = 1; end
            if (prev_stall) begin
                chk({tag, "_hold_valid"}, 32'(pix_valid), 32'(pv));
                chk({tag, "_hold_data"},  32'(pix_data),  32'(pd));
                chk({tag, "_hold_row"},   32'(pix_row),   32'(pr));
                chk({tag, "_hold_col"},   32'(pix_col),   32'(pc));
                chk({tag, "_hold_last"},  32'(pix_last),  32'(pl));
            end
            if (ena) begin
                chk({tag, "_pix_count"}, hs, N * FPS);
                seen_ena = 1;
                ena_cyc.push_back(cyc);
            end else if (pix_valid && pix_ready) begin
                pos = hs % N;
                p4  = 4'(pos);
                chk({tag, "_data"}, 32'(pix_data), 32'(snap[p4]));
                chk({tag, "_row"},  32'(pix_row),  pos / COLS);
                chk({tag, "_col"},  32'(pix_col),  pos % COLS);
                chk({tag, "_last"}, 32'(pix_last), 32'(pos == N - 1));
                hs++;
            end
            prev_stall = pix_valid && !pix_ready;
            pv = pix_valid; pd = pix_data; pl = pix_last; pr = pix_row; pc = pix_col;
            tick();
            guard++;
        end
        step_req = 1'b0;
        if (seen_ena) begin
            chk({tag, "_ena_one_cycle"}, 32'(ena), 0);
            chk({tag, "_valid_after_step"}, 32'(pix_valid), 0);
        end else if (stop_at < 0) begin
            chk({tag, "_timeout"}, 0, 1);
        end
    endtask

    initial begin
        logic [N-1:0] a, b, c, d, e;
        int g0;
        rst = 1'b1; run = 1'b0; step_req = 1'b0; pix_ready = 1'b0; cells_q = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state and quiet idle
        chk("rst_row",  32'(pix_row),  0);
        chk("rst_col",  32'(pix_col),  0);
        chk("rst_data", 32'(pix_data), 0);
        chk("rst_last", 32'(pix_last), 0);
        for (int i = 0; i < 20; i++) begin
            chk("idle_ena",   32'(ena),       0);
            chk("idle_valid", 32'(pix_valid), 0);
            chk("idle_gen",   32'(gen_count), 0);
            chk("idle_busy",  32'(busy),      0);
            tick();
        end

        // Single step with corner pattern
        cells_q = 16'h8001;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        chk("t2_busy", 32'(busy), 1);
        scan_gen(16'h8001, 0, -1, '0, -1, -1, -1, "t2");
        repeat (4) tick();
        chk("t2_gen",  32'(gen_count), 1);
        chk("t2_busy_done", 32'(busy), 0);
        chk("t2_valid_done", 32'(pix_valid), 0);

        // Backpressure: toggling ready, then random ready with random board
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        scan_gen(16'h8001, 1, -1, '0, -1, -1, -1, "t3_toggle");
        repeat (4) tick();
        chk("t3_gen_a", 32'(gen_count), 2);
        a = 16'($urandom);
        cells_q = a;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        cells_q = ~a;
        scan_gen(a, 2, -1, '0, -1, -1, -1, "t3_rand");
        repeat (4) tick();
        chk("t3_gen_b", 32'(gen_count), 3);

        // Free run, snapshot isolation, run dropped mid-frame, ena period
        a = 16'($urandom); b = 16'($urandom); c = 16'($urandom);
        ena_cyc.delete();
        cells_q = a;
        run = 1'b1;
        tick();
        scan_gen(a, 0, 10, b, -1, -1, -1, "t4_g1");
        scan_gen(b, 0, 5, c, -1, -1, -1, "t4_g2");
        scan_gen(c, 0, -1, '0, 3, -1, -1, "t4_g3");
        chk("t4_ena_n", ena_cyc.size(), 3);
        if (ena_cyc.size() == 3) begin
            chk("t4_period_a", ena_cyc[1] - ena_cyc[0], N * FPS + 3);
            chk("t4_period_b", ena_cyc[2] - ena_cyc[1], N * FPS + 3);
        end
        repeat (6) tick();
        chk("t4_park_busy", 32'(busy), 0);
        chk("t4_park_valid", 32'(pix_valid), 0);
        chk("t4_gen", 32'(gen_count), 6);

        // step_req during a scan with run dropped: one more generation follows
        d = 16'($urandom);
        cells_q = d;
        run = 1'b1;
        tick();
        scan_gen(d, 0, -1, '0, 4, 6, -1, "t5_g1");
        scan_gen(d, 2, -1, '0, -1, -1, -1, "t5_g2");
        repeat (8) tick();
        chk("t5_gen", 32'(gen_count), 8);
        chk("t5_busy", 32'(busy), 0);

        // Reset at pixel 7 with a pending step request
        e = 16'($urandom);
        cells_q = e;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        g0 = ena_cyc.size();
        scan_gen(e, 0, -1, '0, -1, 3, 7, "t6");
        chk("t6_at_pix7_col", 32'(pix_col), 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_valid", 32'(pix_valid), 0);
        chk("t6_busy",  32'(busy),      0);
        chk("t6_gen",   32'(gen_count), 0);
        chk("t6_row",   32'(pix_row),   0);
        chk("t6_col",   32'(pix_col),   0);
        for (int i = 0; i < 12; i++) begin
            chk("t6_no_ena",  32'(ena),  0);
            chk("t6_no_busy", 32'(busy), 0);
            tick();
        end
        chk("t6_no_ena_logged", ena_cyc.size(), g0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
